// File: rtl/mips_cpu_muldiv_if.sv
// Request/result bundle for the HI/LO multiply-divide unit.
// The CPU side (master) drives start/op/operands and MTHI/MTLO writes,
// and the unit (slave) returns the HI/LO registers and busy/done status.
interface mips_cpu_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO multiply/divide unit: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
// Iterative, one bit per cycle for 32 cycles on operand magnitudes; signed
// results are sign-corrected while being written to HI/LO on the last edge.
// Build option: define MIPS_CPU_MULDIV_DIV_EN to include the divider.
// Without it, DIV/DIVU complete immediately with HI=LO=0.
module mips_cpu_muldiv #(
  parameter logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  mips_cpu_muldiv_if.slave         bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] p;        // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] d;        // mult: multiplicand magnitude; div: divisor magnitude
  logic        neg_q;    // negate product / quotient at writeback
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        done_r;
`ifdef MIPS_CPU_MULDIV_DIV_EN
  logic        is_div_q;
  logic        rneg_q;   // remainder follows the dividend's sign
  logic        bzero_q;
`endif

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] p_next;
  logic [63:0] res64;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = (state == RUN);
  assign bus.done = done_r;

  // Operand sign detection and magnitudes for the accepting edge.
  always_comb begin
    is_signed = ~bus.op[0];
    a_neg     = is_signed & bus.a[31];
    b_neg     = is_signed & bus.b[31];
    a_mag     = a_neg ? (32'd0 - bus.a) : bus.a;
    b_mag     = b_neg ? (32'd0 - bus.b) : bus.b;
  end

  // One shift-add (multiply) or restoring-subtract (divide) step.
  always_comb begin : step
    logic [32:0] sum;
    logic [32:0] rem_shift;
    logic        ge;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    sum       = {1'b0, p[63:32]} + (p[0] ? {1'b0, d} : 33'd0);
    rem_shift = {p[63:32], p[31]};
    ge        = 1'b0;
    p_next    = {sum, p[31:1]};
`ifdef MIPS_CPU_MULDIV_DIV_EN
    if (is_div_q) begin
      ge     = (rem_shift >= {1'b0, d});
      p_next = {ge ? (rem_shift[31:0] - d) : rem_shift[31:0], p[30:0], ge};
    end
`endif
  end

  // Sign correction of the final step, applied as HI/LO are written.
  always_comb begin
    res64  = neg_q ? (64'd0 - p_next) : p_next;
    hi_res = res64[63:32];
    lo_res = res64[31:0];
`ifdef MIPS_CPU_MULDIV_DIV_EN
    if (is_div_q) begin
      lo_res = bzero_q ? DIV_ZERO_Q : (neg_q ? (32'd0 - p_next[31:0]) : p_next[31:0]);
      hi_res = rneg_q ? (32'd0 - p_next[63:32]) : p_next[63:32];
    end
`endif
  end

  // Control FSM, iteration registers and the HI/LO architectural state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      p        <= 64'd0;
      d        <= 32'd0;
      neg_q    <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      done_r   <= 1'b0;
`ifdef MIPS_CPU_MULDIV_DIV_EN
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // A start takes priority; any MTHI/MTLO in the same cycle is dropped.
            cnt   <= 5'd0;
            neg_q <= a_neg ^ b_neg;
            if (!bus.op[1]) begin
              state <= RUN;
              d     <= a_mag;
              p     <= {32'd0, b_mag};
`ifdef MIPS_CPU_MULDIV_DIV_EN
              is_div_q <= 1'b0;
              rneg_q   <= 1'b0;
              bzero_q  <= 1'b0;
`endif
            end else begin
`ifdef MIPS_CPU_MULDIV_DIV_EN
              state    <= RUN;
              d        <= b_mag;
              p        <= {32'd0, a_mag};
              is_div_q <= 1'b1;
              rneg_q   <= a_neg;
              bzero_q  <= (bus.b == 32'd0);
`else
              hi_r   <= 32'd0;
              lo_r   <= 32'd0;
              done_r <= 1'b1;
`endif
            end
          end else begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi_r   <= hi_res;
            lo_r   <= lo_res;
            done_r <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed self-checking bench for mips_cpu_muldiv (expected values hand-computed).
module tb_mips_cpu_muldiv;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mips_cpu_muldiv_if bus ();

  mips_cpu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and follow it to completion; returns in the done cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit disturb, input bit mt_with_start);
    logic [31:0] hi0, lo0;
    int n;
    bit held;
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.op = o; bus.a = av; bus.b = bv; bus.start = 1'b1;
    if (mt_with_start) begin
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hAAAA5555;
    end
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check({tag, "_busy_e0"}, 64'(bus.busy), 64'd1);
    check({tag, "_done_e0"}, 64'(bus.done), 64'd0);
    n = 0;
    held = 1'b1;
    while (bus.busy && n < 40) begin
      if (bus.hi !== hi0 || bus.lo !== lo0) held = 1'b0;
      if (disturb && n == 5) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd7; bus.b = 32'd7;
        bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
      end
      tick();
      n++;
      bus.start = 1'b0; bus.lo_we = 1'b0;
    end
    check({tag, "_cycles"}, 64'(n), 64'd32);
    check({tag, "_held"}, 64'(held), 64'd1);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    int dones;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    tick();
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // MTHI / MTLO while idle
    bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
    tick();
    bus.hi_we = 1'b0;
    check("mthi", 64'(bus.hi), 64'h12345678);
    bus.lo_we = 1'b1; bus.wdata = 32'hCAFEF00D;
    tick();
    bus.lo_we = 1'b0;
    check("mtlo", 64'(bus.lo), 64'hCAFEF00D);

    // Multiplies; each starts in the previous done cycle (back-to-back)
    run_op("mult_m2x3", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    run_op("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
    run_op("mult_negone", 2'b00, 32'd12345, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7, 1'b0, 1'b0);
    run_op("multu_disturb", 2'b01, 32'd3, 32'd5, 32'h00000000, 32'h0000000F, 1'b1, 1'b0);
    run_op("multu_mtdrop", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b1);

`ifdef MIPS_CPU_MULDIV_DIV_EN
    run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 1'b0);
    run_op("divu_by0", 2'b11, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("div_m7by0", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
`else
    tick();
    check("pre_divoff_done", 64'(bus.done), 64'd0);
    bus.op = 2'b11; bus.a = 32'd10; bus.b = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("divoff_busy", 64'(bus.busy), 64'd0);
    check("divoff_done", 64'(bus.done), 64'd1);
    check("divoff_hi", 64'(bus.hi), 64'd0);
    check("divoff_lo", 64'(bus.lo), 64'd0);
    tick();
    check("divoff_done_end", 64'(bus.done), 64'd0);
    check("divoff_busy_end", 64'(bus.busy), 64'd0);
`endif
    tick();
    check("done_cleared", 64'(bus.done), 64'd0);

    // Reset in the middle of a multiply
    bus.hi_we = 1'b1; bus.wdata = 32'd5;
    tick();
    bus.hi_we = 1'b0;
    check("preset_hi", 64'(bus.hi), 64'd5);
    bus.op = 2'b00; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    #2;
    reset = 1'b1;
    #1;
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_idle", 64'(bus.busy), 64'd0);
    run_op("mult_after_rst", 2'b00, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 1'b0, 1'b0);
    tick();
    check("final_done_low", 64'(bus.done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv.md
MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 SHALL have parameter DIV_ZERO_Q, default 32'hFFFFFFFF: LO value written on divide-by-zero.
REQ-002 SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a new operation.
REQ-005 SHALL have port op, input, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a, input, 32: rs operand (multiplicand/dividend).
REQ-007 SHALL have port b, input, 32: rt operand (multiplier/divisor).
REQ-008 SHALL have port hi_we, input, 1: MTHI write enable.
REQ-009 SHALL have port lo_we, input, 1: MTLO write enable.
REQ-010 SHALL have port wdata, input, 32: MTHI/MTLO data.
REQ-011 SHALL have port hi, output, 32: HI register.
REQ-012 SHALL have port lo, output, 32: LO register.
REQ-013 SHALL have port busy, output, 1: operation in progress.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-015 SHALL accept start only when busy=0; a, b, op latched on the accepting edge E0.
REQ-016 SHALL ignore start while busy=1; no operand capture, no restart.
REQ-017 SHALL use FSM IDLE -> RUN (32 iterations, one bit per cycle) -> IDLE.
REQ-018 SHALL hold busy=1 from E0 until edge E32; at E32 write hi/lo, busy=0, done=1 for exactly one cycle.
REQ-019 MULT/MULTU: {hi,lo} SHALL equal the full 64-bit signed/unsigned product.
REQ-020 DIV/DIVU: lo SHALL be the quotient, hi the remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-021 Signed ops SHALL iterate on magnitudes, with sign correction applied at the E32 write (no extra cycle).
REQ-022 b=0 on DIV/DIVU SHALL give lo=DIV_ZERO_Q, hi=a, with full 32-cycle latency.
REQ-023 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-024 hi_we/lo_we with busy=0 SHALL write wdata into hi/lo on the next edge; writes with busy=1 SHALL be ignored.
REQ-025 start and hi_we/lo_we asserted together with busy=0 SHALL accept the operation; the MTHI/MTLO write is dropped.
REQ-026 hi/lo SHALL hold their prior values throughout RUN, changing only at E32.
REQ-027 A start asserted in the done cycle (busy=0) SHALL be accepted back-to-back.

Reset
REQ-028 reset=1 SHALL asynchronously force state IDLE, busy=0, done=0, hi=0, lo=0, and clear all iteration registers.
REQ-029 Reset asserted mid-RUN SHALL abort the operation; no done pulse and no hi/lo update follows.

Configuration
REQ-030 Macro MIPS_CPU_MULDIV_DIV_EN defined: DIV/DIVU SHALL be implemented as specified above.
REQ-031 Macro MIPS_CPU_MULDIV_DIV_EN undefined: DIV/DIVU SHALL never assert busy, SHALL set hi=0 and lo=0 on the accepting edge, and SHALL pulse done in the following cycle; the divider datapath SHALL be absent. MULT/MULTU SHALL be unchanged.

Verification
REQ-032 MULT a=32'hFFFFFFFE (-2), b=3 -> busy for 32 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, one-cycle done.
REQ-033 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-034 DIV a=-7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-035 MTHI 32'h12345678 while idle -> hi updates next edge; MTLO during RUN -> lo unchanged; start during RUN -> ignored; result matches the first operation.
REQ-036 Reset at cycle 10 of a MULT after preset hi=5 -> hi=lo=0, busy=0, no done pulse; next start completes normally.
REQ-037 Build without MIPS_CPU_MULDIV_DIV_EN: DIVU 10/3 -> busy stays 0, done next cycle, hi=lo=0.
